// File: rtl/hamming_secded_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : hamming_secded_pipe
//  Description : Two-stage pipelined Hamming SEC-DED decoder with a
//                valid/ready stream interface and saturating statistics
//                counters for corrected and uncorrectable words.
//  Revision    : 1.0 - initial release
// ============================================================================
module hamming_secded_pipe #(
    parameter int  DATA_W = 8,
    parameter int  CNT_W  = 16,
    // Smallest P with 2^P >= DATA_W+P+1; the answer is always clog2(DATA_W+1)
    // or one more than that.
    localparam int PAR_W  = ((2 ** $clog2(DATA_W + 1)) >= (DATA_W + $clog2(DATA_W + 1) + 1))
                            ? $clog2(DATA_W + 1) : $clog2(DATA_W + 1) + 1,
    localparam int N      = DATA_W + PAR_W,
    localparam int CODE_W = N + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_status,
    output logic [PAR_W-1:0]  out_err_pos,
    input  logic              cnt_clear,
    output logic [CNT_W-1:0]  cnt_corr,
    output logic [CNT_W-1:0]  cnt_uncorr
);

    localparam logic [1:0]       ST_CLEAN  = 2'b00;
    localparam logic [1:0]       ST_CORR   = 2'b01;
    localparam logic [1:0]       ST_PAR    = 2'b10;
    localparam logic [1:0]       ST_UNCORR = 2'b11;
    localparam logic [PAR_W-1:0] N_P       = PAR_W'(N);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    // Data bits live at the non-power-of-two positions, lowest position at MSB.
    // Position p sits at code bit CODE_W-p.
    function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] code);
        logic [DATA_W-1:0] d;
        int                k;
        d = '0;
        k = 0;
        for (int p = 1; p <= N; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[DATA_W-1-k] = code[CODE_W-p];
                k++;
            end
        end
        return d;
    endfunction

    logic              s1_valid_q;
    logic [CODE_W-1:0] s1_code_q;
    logic [PAR_W-1:0]  s1_syn_q;
    logic              s1_par_q;
    logic [PAR_W-1:0]  syn_d;
    logic              par_d;

    logic              s1_adv;
    logic              s2_adv;
    logic              out_hs;

    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [DATA_W-1:0] out_data_d;
    logic [1:0]        out_status_q;
    logic [1:0]        out_status_d;
    logic [PAR_W-1:0]  out_err_pos_q;
    logic [PAR_W-1:0]  out_err_pos_d;
    logic [CODE_W-1:0] fixed_code;

    logic [CNT_W-1:0]  cnt_corr_q;
    logic [CNT_W-1:0]  cnt_corr_d;
    logic [CNT_W-1:0]  cnt_uncorr_q;
    logic [CNT_W-1:0]  cnt_uncorr_d;

    // Output stage frees when empty or being drained; stage 1 frees when it can move on.
    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;
    assign out_hs   = out_valid_q && out_ready;

    // Syndrome = XOR of indices of set positions; overall parity over the whole word.
    always_comb begin
        syn_d = '0;
        for (int p = 1; p <= N; p++) begin
            if (in_code[CODE_W-p]) begin
                syn_d = syn_d ^ PAR_W'(p);
            end
        end
        par_d = ^in_code;
    end

    // Stage 1 register: capture the codeword with its syndrome and parity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_code_q  <= '0;
            s1_syn_q   <= '0;
            s1_par_q   <= 1'b0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_code_q <= in_code;
                s1_syn_q  <= syn_d;
                s1_par_q  <= par_d;
            end
        end
    end

    // Classify the error pattern and flip the faulty position for single errors.
    always_comb begin
        fixed_code    = s1_code_q;
        out_status_d  = ST_CLEAN;
        out_err_pos_d = '0;
        if (s1_par_q) begin
            if (s1_syn_q == '0) begin
                out_status_d = ST_PAR;
            end else if (s1_syn_q <= N_P) begin
                out_status_d  = ST_CORR;
                out_err_pos_d = s1_syn_q;
                for (int p = 1; p <= N; p++) begin
                    if (s1_syn_q == PAR_W'(p)) begin
                        fixed_code[CODE_W-p] = ~s1_code_q[CODE_W-p];
                    end
                end
            end else begin
                // Odd parity with a syndrome beyond the word: at least three bits bad.
                out_status_d = ST_UNCORR;
            end
        end else if (s1_syn_q != '0) begin
            out_status_d = ST_UNCORR;
        end
        out_data_d = extract_data(fixed_code);
    end

    // Output register: loads on advance, holds its word while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_status_q  <= ST_CLEAN;
            out_err_pos_q <= '0;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_data_q    <= out_data_d;
                out_status_q  <= out_status_d;
                out_err_pos_q <= out_err_pos_d;
            end
        end
    end

    // Counter next state: clear wins, otherwise count delivered words and saturate.
    always_comb begin
        cnt_corr_d   = cnt_corr_q;
        cnt_uncorr_d = cnt_uncorr_q;
        if (cnt_clear) begin
            cnt_corr_d   = '0;
            cnt_uncorr_d = '0;
        end else if (out_hs) begin
            if ((out_status_q == ST_CORR || out_status_q == ST_PAR) && cnt_corr_q != CNT_MAX) begin
                cnt_corr_d = cnt_corr_q + CNT_W'(1);
            end
            if (out_status_q == ST_UNCORR && cnt_uncorr_q != CNT_MAX) begin
                cnt_uncorr_d = cnt_uncorr_q + CNT_W'(1);
            end
        end
    end

    // Statistics counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_corr_q   <= '0;
            cnt_uncorr_q <= '0;
        end else begin
            cnt_corr_q   <= cnt_corr_d;
            cnt_uncorr_q <= cnt_uncorr_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_status  = out_status_q;
    assign out_err_pos = out_err_pos_q;
    assign cnt_corr    = cnt_corr_q;
    assign cnt_uncorr  = cnt_uncorr_q;

endmodule
`default_nettype wire

// File: tb/tb_hamming_secded_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hamming_secded_pipe
//  Description : Self-checking bench for hamming_secded_pipe. The reference
//                decodes by nearest-codeword search over all data values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hamming_secded_pipe;

    localparam int DW = 8;
    localparam int NN = 12;
    localparam int CW = 13;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, out_valid, out_ready, cnt_clear;
    logic [CW-1:0] in_code;
    logic [DW-1:0] out_data;
    logic [1:0]    out_status;
    logic [3:0]    out_err_pos;
    logic [15:0]   cnt_corr, cnt_uncorr;

    logic          s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_cnt_clear;
    logic [CW-1:0] s_in_code;
    logic [DW-1:0] s_out_data;
    logic [1:0]    s_out_status;
    logic [3:0]    s_out_err_pos;
    logic [1:0]    s_cnt_corr, s_cnt_uncorr;

    int            checks = 0;
    int            errors = 0;
    logic          rand_mode = 1'b0;
    logic          ready_force = 1'b1;
    logic [13:0]   q[$];
    logic [15:0]   mc, mu;
    logic          hold = 1'b0;
    logic [13:0]   held;

    hamming_secded_pipe #(.DATA_W(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_status(out_status),
        .out_err_pos(out_err_pos), .cnt_clear(cnt_clear), .cnt_corr(cnt_corr), .cnt_uncorr(cnt_uncorr));

    hamming_secded_pipe #(.DATA_W(8), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_code(s_in_code),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .out_status(s_out_status),
        .out_err_pos(s_out_err_pos), .cnt_clear(s_cnt_clear), .cnt_corr(s_cnt_corr), .cnt_uncorr(s_cnt_uncorr));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Textbook encoder: data into non-power-of-two positions (first at MSB),
    // check bit 2^i = XOR of data positions having bit i set, then overall parity.
    function automatic logic [CW-1:0] encode(input logic [DW-1:0] d);
        logic [CW-1:0] c;
        int            k;
        logic          pb;
        c = '0;
        k = 0;
        for (int p = 1; p <= NN; p++)
            if ((p & (p - 1)) != 0) begin
                c[CW-p] = d[DW-1-k];
                k++;
            end
        for (int i = 0; i < 4; i++) begin
            pb = 1'b0;
            for (int p = 1; p <= NN; p++)
                if (((p & (p - 1)) != 0) && ((p >> i) & 1) == 1) pb = pb ^ c[CW-p];
            c[CW-(1 << i)] = pb;
        end
        c[0] = ^c[CW-1:1];
        return c;
    endfunction

    function automatic logic [DW-1:0] raw_data(input logic [CW-1:0] c);
        logic [DW-1:0] d;
        int            k;
        d = '0;
        k = 0;
        for (int p = 1; p <= NN; p++)
            if ((p & (p - 1)) != 0) begin
                d[DW-1-k] = c[CW-p];
                k++;
            end
        return d;
    endfunction

    // Expected {data, status, err_pos}: exact codeword -> clean; one bit away from
    // a codeword -> that codeword (parity-only if the differing bit is bit 0);
    // anything else -> uncorrectable with raw data.
    function automatic logic [13:0] model(input logic [CW-1:0] r);
        logic [CW-1:0] diff;
        logic [DW-1:0] dd;
        logic [3:0]    pos;
        dd = raw_data(r);
        for (int d = 0; d < 256; d++) begin
            diff = encode(d[7:0]) ^ r;
            if (diff == '0) return {d[7:0], 2'b00, 4'd0};
            if ($countones(diff) == 1) begin
                if (diff[0]) return {d[7:0], 2'b10, 4'd0};
                pos = 4'd0;
                for (int b = 1; b < CW; b++) if (diff[b]) pos = 4'(CW - b);
                return {d[7:0], 2'b01, pos};
            end
        end
        return {dd, 2'b11, 4'd0};
    endfunction

    // Consumer ready pattern: random in random mode, otherwise forced by the main flow.
    always @(posedge clk) begin
        #1;
        if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
        else           out_ready = ready_force;
    end

    // Compare process: outputs against the reference queue, counters, stall stability.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_word", {out_data, out_status, out_err_pos}, 0);
            chk("rst_cnt", {cnt_corr, cnt_uncorr}, 0);
            q.delete();
            mc   = '0;
            mu   = '0;
            hold = 1'b0;
        end else begin
            chk("cnt_corr", cnt_corr, mc);
            chk("cnt_uncorr", cnt_uncorr, mu);
            if (hold) begin
                chk("stall_valid_held", out_valid, 1);
                chk("stall_word_held", {out_data, out_status, out_err_pos}, held);
            end
            if (out_valid) begin
                chk("out_has_expected", q.size() != 0, 1);
                if (q.size() != 0) chk("out_word", {out_data, out_status, out_err_pos}, q[0]);
            end
            if (cnt_clear) begin
                mc = '0;
                mu = '0;
            end else if (out_valid && out_ready && q.size() != 0) begin
                if ((q[0][5:4] == 2'b01 || q[0][5:4] == 2'b10) && mc != 16'hFFFF) mc++;
                if (q[0][5:4] == 2'b11 && mu != 16'hFFFF) mu++;
            end
            if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
            if (in_valid && in_ready) q.push_back(model(in_code));
            hold = out_valid && !out_ready;
            held = {out_data, out_status, out_err_pos};
        end
    end

    // Present a word from posedge+1 until accepted; returns just after the accepting edge.
    task automatic send(input logic [CW-1:0] c);
        int t;
        t        = 0;
        in_valid = 1'b1;
        in_code  = c;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("send_timeout", t < 100, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int t;
        t = 0;
        while ((q.size() != 0 || out_valid) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", t < 500, 1);
        @(posedge clk);
        #1;
    endtask

    logic [CW-1:0] codes[5]  = '{13'h1DDE, 13'h1D5E, 13'h1DDF, 13'h18DE, 13'h0FFE};
    logic [13:0]   exps[5]   = '{{8'hFF, 2'b00, 4'd0}, {8'hFF, 2'b01, 4'd6}, {8'hFF, 2'b10, 4'd0},
                                 {8'h3F, 2'b11, 4'd0}, {8'hFF, 2'b11, 4'd0}};
    logic [15:0]   exp_cc[5] = '{16'd0, 16'd1, 16'd2, 16'd2, 16'd2};
    logic [15:0]   exp_cu[5] = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd2};
    logic [CW-1:0] rc, rm;
    logic          saw_low;

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_code = '0; cnt_clear = 1'b0; out_ready = 1'b1;
        s_in_valid = 1'b0; s_in_code = '0; s_out_ready = 1'b1; s_cnt_clear = 1'b0;

        // Pin the reference to hand-derived values.
        chk("model_encode_ff", encode(8'hFF), 13'h1DDE);
        for (int i = 0; i < 5; i++) chk("model_literal", model(codes[i]), exps[i]);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Directed words: latency, literal results, running counters.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            send(codes[i]);
            @(negedge clk);
            chk("latency_early", out_valid, 0);
            @(negedge clk);
            chk("latency_valid", out_valid, 1);
            chk("directed_word", {out_data, out_status, out_err_pos}, exps[i]);
            @(negedge clk);
            chk("directed_cnt_corr", cnt_corr, exp_cc[i]);
            chk("directed_cnt_uncorr", cnt_uncorr, exp_cu[i]);
        end
        wait_empty();

        // Six back-to-back words with the consumer stalled for three cycles.
        saw_low = 1'b0;
        fork
            for (int i = 0; i < 6; i++) send(encode(8'(8'h10 + i)) ^ (i[0] ? 13'h0100 : 13'h0));
            begin
                repeat (3) @(posedge clk);
                ready_force = 1'b0;
                repeat (3) @(posedge clk);
                ready_force = 1'b1;
            end
            repeat (12) begin
                @(negedge clk);
                if (!in_ready) saw_low = 1'b1;
            end
        join
        chk("stream_in_ready_dropped", saw_low, 1);
        wait_empty();

        // Randomised traffic with random backpressure and occasional counter clears.
        rand_mode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            rc = encode(8'($urandom));
            rm = '0;
            repeat ($urandom_range(0, 3)) rm = rm | (13'd1 << $urandom_range(0, CW - 1));
            if ($urandom_range(0, 7) == 0) rc = 13'($urandom);
            cnt_clear = ($urandom_range(0, 31) == 0);
            send(rc ^ rm);
            cnt_clear = 1'b0;
        end
        wait_empty();
        rand_mode = 1'b0;

        // Reset with two words in flight.
        send(codes[1]);
        send(codes[3]);
        rst = 1'b1;
        #1 chk("rst_immediate_valid", out_valid, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("no_stale_after_rst", out_valid, 0);
        end
        @(posedge clk); #1;
        send(codes[0]);
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_word", {out_data, out_status, out_err_pos}, exps[0]);
        wait_empty();

        // Narrow counters: saturation, then clear colliding with a counted handshake.
        s_in_valid = 1'b1;
        s_in_code  = 13'h1D5E;
        repeat (5) @(posedge clk);
        #1 s_in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("sat_cnt_corr", s_cnt_corr, 2'd3);
        chk("sat_cnt_uncorr", s_cnt_uncorr, 2'd0);
        @(posedge clk); #1 s_in_valid = 1'b1;
        @(posedge clk); #1 s_in_valid = 1'b0;
        @(posedge clk); #1 s_cnt_clear = 1'b1;
        @(negedge clk);
        chk("clr_word_valid", s_out_valid, 1);
        chk("clr_word", {s_out_data, s_out_status, s_out_err_pos}, {8'hFF, 2'b01, 4'd6});
        @(posedge clk); #1 s_cnt_clear = 1'b0;
        @(negedge clk);
        chk("clr_priority", s_cnt_corr, 2'd0);
        repeat (3) @(negedge clk);
        chk("clr_stays_zero", s_cnt_corr, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
